// File: rtl/comb.sv
// Warning-logic leaf cell: L = (D AND X) OR A, plus a registered copy of L,
// a rising-edge pulse and a saturating count of those pulses.
module comb #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             D,
   input  logic             X,
   input  logic             A,
   input  logic             cnt_clr,
   output logic             L,
   output logic             L_r,
   output logic             L_rise,
   output logic [CNT_W-1:0] L_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             l_r_reg;
   logic             l_r_prev_reg;
   logic [CNT_W-1:0] l_cnt_reg;
   logic [CNT_W-1:0] l_cnt_next;
   logic             rise;

   assign L    = (D & X) | A;
   assign rise = l_r_reg & ~l_r_prev_reg;

   // Clear wins over a coincident rise; the counter holds at all-ones.
   always_comb begin
      l_cnt_next = l_cnt_reg;
      if (cnt_clr)
         l_cnt_next = '0;
      else if (rise && (l_cnt_reg != CNT_MAX))
         l_cnt_next = l_cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_r_reg      <= 1'b0;
         l_r_prev_reg <= 1'b0;
         l_cnt_reg    <= '0;
      end else begin
         l_r_reg      <= L;
         l_r_prev_reg <= l_r_reg;
         l_cnt_reg    <= l_cnt_next;
      end
   end

   assign L_r    = l_r_reg;
   assign L_rise = rise;
   assign L_cnt  = l_cnt_reg;

endmodule

// File: tb/tb_comb.sv
// Self-checking bench for comb: directed scenarios plus random stimulus,
// compared against a table-driven behavioural model of the cell.
module tb_comb;

   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             D, X, A, cnt_clr;
   logic             L, L_r, L_rise;
   logic [CNT_W-1:0] L_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: truth table of L indexed by {D,X,A}, last two samples of L, event count.
   logic [7:0] l_table = 8'hEA;
   logic       m_lr, m_prev;
   int         m_cnt;

   comb #(.CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .D      (D),
      .X      (X),
      .A      (A),
      .cnt_clr(cnt_clr),
      .L      (L),
      .L_r    (L_r),
      .L_rise (L_rise),
      .L_cnt  (L_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic l_of(input logic d, input logic x, input logic a);
      logic [2:0] idx;
      idx = {d, x, a};
      return l_table[idx];
   endfunction

   task automatic model_reset();
      m_lr   = 1'b0;
      m_prev = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".L"}, int'(L), int'(l_of(D, X, A)));
      check({tag, ".L_r"}, int'(L_r), int'(m_lr));
      check({tag, ".L_rise"}, int'(L_rise), int'(m_lr & ~m_prev));
      check({tag, ".L_cnt"}, int'(L_cnt), m_cnt);
   endtask

   task automatic drive(input logic d, input logic x, input logic a, input logic clr);
      D = d; X = x; A = a; cnt_clr = clr;
   endtask

   // One clock: advance the model from the values present at the edge, then compare.
   task automatic tick(input string tag);
      logic l_now;
      logic rise_old;
      l_now    = l_of(D, X, A);
      rise_old = m_lr & ~m_prev;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (cnt_clr)
            m_cnt = 0;
         else if (rise_old && m_cnt < CNT_MAX)
            m_cnt = m_cnt + 1;
         m_prev = m_lr;
         m_lr   = l_now;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0);
      model_reset();
      #2;
      check_all("reset");

      // Combinational sweep while held in reset: L follows inputs, registers stay 0.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         drive(v[2], v[1], v[0], 0);
         #1;
         check("sweep.L", int'(L), int'(l_of(v[2], v[1], v[0])));
         check("sweep.L_formula", int'(L), int'((v[2] & v[1]) | v[0]));
         check("sweep.L_r", int'(L_r), 0);
         #9;
      end

      drive(0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Registered path: 000 -> 001, one rise, count reaches 1.
      tick("idle");
      drive(0, 0, 1, 0);
      tick("first");
      check("first.rise", int'(L_rise), 1);
      tick("first2");
      check("first.cnt", int'(L_cnt), 1);
      check("first.rise_gone", int'(L_rise), 0);

      // Level hold: A kept high for 5 cycles gives no extra pulses.
      for (int i = 0; i < 5; i++) tick("hold");
      check("hold.cnt", int'(L_cnt), 1);
      drive(0, 0, 0, 0);
      tick("fall");

      // Saturation: 300 rising edges on L must stop the count at all-ones.
      for (int i = 0; i < 300; i++) begin
         drive(0, 0, 1, 0);
         tick("sat_hi");
         drive(0, 0, 0, 0);
         tick("sat_lo");
      end
      check("sat.cnt", int'(L_cnt), CNT_MAX);

      drive(0, 0, 0, 1);
      tick("clr");
      check("clr.cnt", int'(L_cnt), 0);

      // Clear coincident with a rise: clear wins.
      drive(1, 1, 0, 0);
      tick("co_rise");
      check("co.rise", int'(L_rise), 1);
      drive(1, 1, 0, 1);
      tick("co_clr");
      check("co.cnt", int'(L_cnt), 0);
      drive(0, 0, 0, 0);
      tick("co_after");
      check("co.cnt_after", int'(L_cnt), 0);

      // Random stimulus with occasional clears.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
         #1;
         check("rand.L", int'(L), int'(l_of(D, X, A)));
         tick("rand");
      end

      // Async reset with L_r = 1 and L_cnt = 5, asserted mid-cycle.
      drive(0, 0, 0, 1);
      tick("pre_clr");
      drive(0, 0, 0, 0);
      tick("pre_lo");
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0, 0);
         tick("pre_hi");
         drive(0, 0, 0, 0);
         tick("pre_lo");
      end
      drive(0, 1, 1, 0);
      tick("pre_last");
      check("pre.L_r", int'(L_r), 1);
      check("pre.cnt", int'(L_cnt), 5);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst.L_r", int'(L_r), 0);
      check("arst.L_rise", int'(L_rise), 0);
      check("arst.L_cnt", int'(L_cnt), 0);
      check("arst.L", int'(L), 1);
      drive(1, 0, 0, 0);
      #1;
      check("arst.L_follow", int'(L), 0);
      tick("in_reset");
      drive(1, 1, 0, 0);
      tick("in_reset2");
      @(negedge clk);
      rst_n = 1'b1;
      tick("post_reset");
      check("post.rise", int'(L_rise), 1);
      tick("post_reset2");
      check("post.cnt", int'(L_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
